// File: rtl/dcache_blocking_resp.sv
// Blocking dcache responder: direct-mapped write-through store plus a miss/write-through FSM.
// Optional hit/miss counters are enabled with DCACHE_BLOCKING_RESP_STATS_EN.
package dcache_blocking_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic {OP_LOAD = 1'b0, OP_STORE = 1'b1} op_e;
  typedef struct packed {
    op_e               op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } resp_t;
endpackage

module dcache_blocking_resp
  import dcache_blocking_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid_r,
  input  logic              s1_valid_r,
  input  cmd_t              s1_cmd_r,
  input  logic              s2_valid_r,
  input  cmd_t              s2_cmd_r,
  input  logic              s3_replay_r,
  output logic              busy_r,
  output logic              resp_valid_r,
  output resp_t             resp_w,
  output logic              resp_replay_r,
  output logic              resp_replay_inv_r,
  output logic              mem_req_valid_r,
  output logic              mem_req_wr_r,
  output logic [ADDR_W-1:0] mem_req_addr_r,
  output logic [DATA_W-1:0] mem_req_data_r,
  input  logic              mem_req_accept,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [31:0]       stat_hit_r,
  output logic [31:0]       stat_miss_r
);
  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL_REQ, ST_FILL_WAIT, ST_WT_REQ} state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                busy_d, resp_replay_d, resp_inv_d;
  logic                req_valid_d, req_wr_d;
  logic [ADDR_W-1:0]   req_addr_d;
  logic [DATA_W-1:0]   req_data_d;

  logic [IDX_W-1:0]    s1_idx, s2_idx, fill_idx;
  logic [TAG_W-1:0]    s1_tag, s2_tag, fill_tag;
  logic                s1_load, s2_load, s1_hit, s2_hit;
  logic                s2_go, s2_miss, s2_store_commit, fill_we, store_we;

  assign s1_idx   = s1_cmd_r.addr[OFF_W +: IDX_W];
  assign s1_tag   = s1_cmd_r.addr[ADDR_W-1 -: TAG_W];
  assign s2_idx   = s2_cmd_r.addr[OFF_W +: IDX_W];
  assign s2_tag   = s2_cmd_r.addr[ADDR_W-1 -: TAG_W];
  assign fill_idx = mem_req_addr_r[OFF_W +: IDX_W];
  assign fill_tag = mem_req_addr_r[ADDR_W-1 -: TAG_W];
  assign s1_load  = (s1_cmd_r.op == OP_LOAD);
  assign s2_load  = (s2_cmd_r.op == OP_LOAD);
  assign s1_hit   = valid_q[s1_idx] && (tag_q[s1_idx] == s1_tag);
  assign s2_hit   = valid_q[s2_idx] && (tag_q[s2_idx] == s2_tag);

  assign s2_go           = s2_valid_r & ~resp_replay_r & ~s3_replay_r;
  assign s2_miss         = s2_valid_r & resp_replay_r & s2_load & (state_q == ST_IDLE) & ~s3_replay_r;
  assign s2_store_commit = s2_go & ~s2_load;
  assign fill_we         = (state_q == ST_FILL_WAIT) & mem_rsp_valid;
  // Store misses leave the array alone; only the write-through goes out.
  assign store_we        = s2_store_commit & s2_hit;

  always_comb begin
    state_d     = state_q;
    req_valid_d = mem_req_valid_r;
    req_wr_d    = mem_req_wr_r;
    req_addr_d  = mem_req_addr_r;
    req_data_d  = mem_req_data_r;
    unique case (state_q)
      ST_IDLE: begin
        if (s2_miss) begin
          state_d     = ST_FILL_REQ;
          req_valid_d = 1'b1;
          req_wr_d    = 1'b0;
          req_addr_d  = {s2_cmd_r.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end else if (s2_store_commit) begin
          state_d     = ST_WT_REQ;
          req_valid_d = 1'b1;
          req_wr_d    = 1'b1;
          req_addr_d  = {s2_cmd_r.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          req_data_d  = s2_cmd_r.data;
        end
      end
      ST_FILL_REQ: if (mem_req_accept) begin
        state_d     = ST_FILL_WAIT;
        req_valid_d = 1'b0;
      end
      ST_FILL_WAIT: if (mem_rsp_valid) state_d = ST_IDLE;
      ST_WT_REQ: if (mem_req_accept) begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_we) valid_d[fill_idx] = 1'b1;
    busy_d        = (state_d != ST_IDLE);
    resp_replay_d = s1_valid_r & ((s1_load & ~s1_hit) | busy_d);
    // A hit load that reads the line a store is writing this cycle saw stale data.
    resp_inv_d    = s1_valid_r & s1_load & s1_hit & s2_store_commit & (s2_idx == s1_idx);
    resp_data_d   = data_q[s1_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      valid_q           <= '0;
      busy_r            <= 1'b0;
      resp_valid_r      <= 1'b0;
      resp_replay_r     <= 1'b0;
      resp_replay_inv_r <= 1'b0;
      resp_data_q       <= '0;
      mem_req_valid_r   <= 1'b0;
      mem_req_wr_r      <= 1'b0;
      mem_req_addr_r    <= '0;
      mem_req_data_r    <= '0;
    end else begin
      state_q           <= state_d;
      valid_q           <= valid_d;
      busy_r            <= busy_d;
      resp_valid_r      <= s1_valid_r;
      resp_replay_r     <= resp_replay_d;
      resp_replay_inv_r <= resp_inv_d;
      resp_data_q       <= resp_data_d;
      mem_req_valid_r   <= req_valid_d;
      mem_req_wr_r      <= req_wr_d;
      mem_req_addr_r    <= req_addr_d;
      mem_req_data_r    <= req_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rsp_data;
    end else if (store_we) begin
      data_q[s2_idx] <= s2_cmd_r.data;
    end
  end

  assign resp_w = resp_t'(resp_data_q);

`ifdef DCACHE_BLOCKING_RESP_STATS_EN
  logic [31:0] stat_hit_q, stat_hit_d, stat_miss_q, stat_miss_d;
  logic        hit_inc;
  assign hit_inc = resp_valid_r & s2_load & ~resp_replay_r & ~s3_replay_r;

  always_comb begin
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
    if (hit_inc && stat_hit_q != 32'hFFFF_FFFF) stat_hit_d = stat_hit_q + 32'd1;
    if (s2_miss && stat_miss_q != 32'hFFFF_FFFF) stat_miss_d = stat_miss_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_hit_r  = stat_hit_q;
  assign stat_miss_r = stat_miss_q;
`else
  assign stat_hit_r  = '0;
  assign stat_miss_r = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s0_valid_r, s1_cmd_r.data, s1_cmd_r.addr[OFF_W-1:0], s2_cmd_r.addr[OFF_W-1:0]};
endmodule

// File: tb/tb_dcache_blocking_resp.sv
// Scoreboard bench for dcache_blocking_resp: a tiny replaying pipe, a backing-memory model and
// an architectural memory image that every completed load must agree with.
module tb_dcache_blocking_resp;
  import dcache_blocking_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              s0_valid_r, s1_valid_r, s2_valid_r, s3_replay_r;
  cmd_t              s1_cmd_r, s2_cmd_r;
  logic              busy_r, resp_valid_r, resp_replay_r, resp_replay_inv_r;
  resp_t             resp_w;
  logic              mem_req_valid_r, mem_req_wr_r, mem_req_accept, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_req_addr_r;
  logic [DATA_W-1:0] mem_req_data_r, mem_rsp_data;
  logic [31:0]       stat_hit_r, stat_miss_r;

  dcache_blocking_resp #(.LINES(16)) dut (
    .clk(clk), .rst(rst), .s0_valid_r(s0_valid_r),
    .s1_valid_r(s1_valid_r), .s1_cmd_r(s1_cmd_r),
    .s2_valid_r(s2_valid_r), .s2_cmd_r(s2_cmd_r), .s3_replay_r(s3_replay_r),
    .busy_r(busy_r), .resp_valid_r(resp_valid_r), .resp_w(resp_w),
    .resp_replay_r(resp_replay_r), .resp_replay_inv_r(resp_replay_inv_r),
    .mem_req_valid_r(mem_req_valid_r), .mem_req_wr_r(mem_req_wr_r),
    .mem_req_addr_r(mem_req_addr_r), .mem_req_data_r(mem_req_data_r),
    .mem_req_accept(mem_req_accept), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .stat_hit_r(stat_hit_r), .stat_miss_r(stat_miss_r)
  );

  int n_cmp = 0, n_err = 0;
  logic [31:0] gmem [logic [31:0]];
  cmd_t        op_q[$];
  logic [31:0] exp_ld_q[$];
  logic [31:0] fill_q[$];
  logic [63:0] wt_q[$];

  int  issue_pct = 100, s3_pct = 0, acc_pct = 100, dly_min = 0, dly_max = 3;
  bit  acc_block = 0, force_s3 = 0, ignore_busy = 0;
  int  exp_hits = 0, exp_miss = 0, inv_seen = 0, rd_acc_cnt = 0, wr_acc_cnt = 0;
  bit  fill_pend = 0;
  int  rsp_cnt = 0;
  logic [31:0] fill_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wa(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (gmem.exists(a)) return gmem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic cmd_t mk(input op_e op, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.op = op; c.addr = a; c.data = d;
    return c;
  endfunction

  // One pipe cycle: S1 moves to S2, the S2 op's fate is decided, a new op may enter S1.
  task automatic step();
    bit s3;
    @(posedge clk); #1;
    s2_valid_r = s1_valid_r;
    s2_cmd_r   = s1_cmd_r;
    s3 = 1'b0;
    if (s2_valid_r) s3 = force_s3 || ($urandom % 100 < s3_pct);
    if (s2_valid_r) force_s3 = 1'b0;
    s3_replay_r = s3;
    if (s2_valid_r) begin
      if (resp_replay_inv_r) inv_seen++;
      if (resp_valid_r && s2_cmd_r.op == OP_LOAD && !resp_replay_r && !s3) exp_hits++;
      if (s2_cmd_r.op == OP_LOAD && resp_replay_r && !busy_r && !s3) begin
        exp_miss++;
        fill_q.push_back(wa(s2_cmd_r.addr));
      end
      if (s3 || resp_replay_r || resp_replay_inv_r) op_q.push_front(s2_cmd_r);
      else if (s2_cmd_r.op == OP_LOAD) exp_ld_q.push_back(mem_rd(wa(s2_cmd_r.addr)));
      else begin
        gmem[wa(s2_cmd_r.addr)] = s2_cmd_r.data;
        wt_q.push_back({wa(s2_cmd_r.addr), s2_cmd_r.data});
      end
    end
    if ((ignore_busy || !busy_r) && op_q.size() > 0 && ($urandom % 100 < issue_pct)) begin
      s1_valid_r = 1'b1;
      s1_cmd_r   = op_q.pop_front();
    end else s1_valid_r = 1'b0;
    s0_valid_r = (op_q.size() > 0);
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    do begin
      step(); n++;
    end while (!(op_q.size() == 0 && !s1_valid_r && !s2_valid_r && !busy_r &&
                 !mem_req_valid_r && !fill_pend) && n < budget);
    chk({tag, "_budget_expired"}, 64'(n >= budget), 0);
    chk({tag, "_sb_empty"}, 64'(exp_ld_q.size() + wt_q.size() + fill_q.size()), 0);
  endtask

  task automatic clear_pipe();
    s0_valid_r = 0; s1_valid_r = 0; s2_valid_r = 0; s3_replay_r = 0;
    op_q.delete(); exp_ld_q.delete(); fill_q.delete(); wt_q.delete();
    exp_hits = 0; exp_miss = 0; force_s3 = 0;
  endtask

  // Load checker: pops whenever the DUT presents a completed load in S2.
  always @(negedge clk) begin
    if (!rst && s2_valid_r && s2_cmd_r.op == OP_LOAD && resp_valid_r && !resp_replay_r &&
        !resp_replay_inv_r && !s3_replay_r) begin
      chk("load_expected", 64'(exp_ld_q.size() > 0), 1);
      if (exp_ld_q.size() > 0) chk("load_data", resp_w.data, exp_ld_q.pop_front());
    end
  end

  // Backing memory: random accept, delayed fills, occasional stray responses.
  always @(negedge clk) begin
    if (rst) begin
      fill_pend = 0; mem_req_accept = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    end else begin
      mem_rsp_valid = 0;
      if (fill_pend) begin
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1; mem_rsp_data = mem_rd(fill_addr); fill_pend = 0;
        end else rsp_cnt--;
      end else if ($urandom % 100 < 3) begin
        mem_rsp_valid = 1; mem_rsp_data = $urandom;
      end
      mem_req_accept = 0;
      if (mem_req_valid_r && !acc_block && ($urandom % 100 < acc_pct)) begin
        mem_req_accept = 1;
        if (mem_req_wr_r) begin
          logic [63:0] e;
          wr_acc_cnt++;
          chk("wt_expected", 64'(wt_q.size() > 0), 1);
          if (wt_q.size() > 0) begin
            e = wt_q.pop_front();
            chk("wt_addr", mem_req_addr_r, e[63:32]);
            chk("wt_data", mem_req_data_r, e[31:0]);
          end
        end else begin
          rd_acc_cnt++;
          chk("fill_expected", 64'(fill_q.size() > 0), 1);
          if (fill_q.size() > 0) chk("fill_addr", mem_req_addr_r, fill_q.pop_front());
          fill_pend = 1; fill_addr = mem_req_addr_r;
          rsp_cnt = $urandom_range(dly_max, dly_min);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_r, 0);
    chk({tag, "_resp_valid"}, resp_valid_r, 0);
    chk({tag, "_replay"}, {resp_replay_r, resp_replay_inv_r}, 0);
    chk({tag, "_resp_data"}, resp_w.data, 0);
    chk({tag, "_mem_req"}, {mem_req_valid_r, mem_req_wr_r, mem_req_addr_r, mem_req_data_r}, 0);
    chk({tag, "_stats"}, {stat_hit_r, stat_miss_r}, 0);
  endtask

  initial begin
    int base, n;
    logic [31:0] a0;
    rst = 1; s1_cmd_r = '0; s2_cmd_r = '0;
    clear_pipe();
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst = 0;

    // Cold load 0x40 misses, fills from memory, then hits on reissue.
    gmem[32'h40] = 32'hDEAD_BEEF;
    base = rd_acc_cnt;
    dly_min = 3; dly_max = 3;
    op_q.push_back(mk(OP_LOAD, 32'h40, 0));
    run_idle(100, "cold");
    chk("cold_fill_count", rd_acc_cnt - base, 1);
    dly_min = 0;

    // Store hit then load of the same word.
    base = wr_acc_cnt;
    op_q.push_back(mk(OP_STORE, 32'h40, 32'h1234));
    op_q.push_back(mk(OP_LOAD, 32'h40, 0));
    run_idle(100, "store_hit");
    chk("store_wt_count", wr_acc_cnt - base, 1);

    // Store in S2 with a hitting load of the same line in S1.
    base = inv_seen;
    op_q.push_back(mk(OP_STORE, 32'h40, 32'h5678));
    op_q.push_back(mk(OP_LOAD, 32'h41, 0));
    run_idle(100, "inv");
    chk("inv_flagged", 64'(inv_seen > base), 1);

    // Fill request held off for 10 cycles with ops forced into S1.
    acc_block = 1;
    op_q.push_back(mk(OP_LOAD, 32'h80, 0));
    n = 0;
    while (!mem_req_valid_r && n < 20) begin step(); n++; end
    chk("stall_req_seen", mem_req_valid_r, 1);
    a0 = mem_req_addr_r;
    ignore_busy = 1;
    for (int i = 0; i < 10; i++) begin
      if (op_q.size() == 0) op_q.push_back(mk(OP_LOAD, 32'h40, 0));
      step();
      chk("stall_req", {mem_req_valid_r, mem_req_wr_r, mem_req_addr_r}, {1'b1, 1'b0, a0});
      chk("stall_busy", busy_r, 1);
      if (s2_valid_r) chk("stall_replay", resp_replay_r, 1);
    end
    ignore_busy = 0; acc_block = 0;
    run_idle(200, "stall");

    // Late replay kills an S2 miss: no memory request may follow.
    base = rd_acc_cnt;
    force_s3 = 1;
    op_q.push_back(mk(OP_LOAD, 32'hC4, 0));
    step(); issue_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s3_kill_idle", {busy_r, mem_req_valid_r}, 0);
    end
    chk("s3_kill_no_fill", rd_acc_cnt - base, 0);
    issue_pct = 100;
    run_idle(100, "s3_kill");

    // Randomized traffic over a few conflicting lines.
    issue_pct = 70; s3_pct = 5; acc_pct = 50; dly_max = 4;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(3, 0) << 6) | ($urandom_range(3, 0) << 2) | $urandom_range(3, 0);
      op_q.push_back(mk(($urandom % 100 < 35) ? OP_STORE : OP_LOAD, a, $urandom));
    end
    run_idle(20000, "random");
`ifdef DCACHE_BLOCKING_RESP_STATS_EN
    chk("stat_hit", stat_hit_r, exp_hits);
    chk("stat_miss", stat_miss_r, exp_miss);
`else
    chk("stat_hit", stat_hit_r, 0);
    chk("stat_miss", stat_miss_r, 0);
`endif

    // Reset while waiting on a fill; line 0 must be invalid afterwards.
    issue_pct = 100; s3_pct = 0; acc_pct = 100; dly_min = 20; dly_max = 20;
    op_q.push_back(mk(OP_LOAD, 32'h100, 0));
    n = 0;
    while (!(fill_pend && !mem_req_valid_r && busy_r) && n < 50) begin step(); n++; end
    chk("rst_in_fill_wait", {fill_pend, mem_req_valid_r, busy_r}, {1'b1, 1'b0, 1'b1});
    #2 rst = 1;
    clear_pipe();
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk); #1 rst = 0;
    dly_min = 0; dly_max = 3;
    op_q.push_back(mk(OP_LOAD, 32'h40, 0));
    n = 0;
    do begin step(); n++; end while (!s2_valid_r && n < 10);
    chk("post_rst_miss", {s2_valid_r, resp_replay_r}, 2'b11);
    run_idle(100, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
